// File: rtl/alu_defs_pkg.sv
// Shared opcode, FSM state and sizing definitions for the shared-ALU controller.
package alu_defs_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic is_legal_opcode(input logic [4:0] op);
    return op <= ALU_SRA;
  endfunction

  // Only arithmetic ops report a meaningful overflow flag.
  function automatic logic is_addsub(input logic [4:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin arbiter; last_grant moves only when a grant is consumed.
module alu_rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic       advance,
  output logic       grant
);

  logic last_grant;

  // Out of reset port 0 wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (advance) begin
      last_grant <= grant;
    end
  end

  always_comb begin
    grant = 1'b0;
    if (&req_valid) begin
      grant = ~last_grant;
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two valid/ready requesters,
// one operation in flight, registered ALU inputs and registered responses.
module alu_share_ctrl
  import alu_defs_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_opcode,
  input  logic [2*OP_W-1:0]   req_shamt,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          resp_valid,
  input  logic [1:0]          resp_ready,
  output logic [DATA_W-1:0]   resp_result,
  output logic                resp_ne,
  output logic                resp_lt,
  output logic                resp_ovf,
  output logic                resp_err,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [OP_W-1:0]     alu_shamt,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_ne,
  input  logic                alu_lt,
  input  logic                alu_ovf
);

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             grant, grant_q, ill_q;
  logic             accept, resp_hs, sel_legal, done;
  logic [OP_W-1:0]  sel_opcode, sel_shamt;
  logic [DATA_W-1:0] sel_a, sel_b;

  alu_rr_arbiter u_arb (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .advance   (accept),
    .grant     (grant)
  );

  always_comb begin
    sel_opcode = grant ? req_opcode[2*OP_W-1:OP_W]     : req_opcode[OP_W-1:0];
    sel_shamt  = grant ? req_shamt[2*OP_W-1:OP_W]      : req_shamt[OP_W-1:0];
    sel_a      = grant ? req_a[2*DATA_W-1:DATA_W]      : req_a[DATA_W-1:0];
    sel_b      = grant ? req_b[2*DATA_W-1:DATA_W]      : req_b[DATA_W-1:0];
    sel_legal  = is_legal_opcode(sel_opcode);
  end

  // Ready is offered only in IDLE, and is forced low while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if ((state == ST_IDLE) && !reset && req_valid[grant]) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept  = |(req_valid & req_ready);
  assign resp_hs = resp_valid[grant_q] & resp_ready[grant_q];
  assign done    = (state == ST_EXEC) && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Illegal ops spend one EXEC cycle so their response timing matches a 1-cycle op.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_EXEC;
          cnt_next   = sel_legal ? CNT_W'(ALU_LATENCY - 1) : '0;
        end
      end
      ST_EXEC: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_hs) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q     <= 1'b0;
      ill_q       <= 1'b0;
      alu_opcode  <= '0;
      alu_shamt   <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_ne     <= 1'b0;
      resp_lt     <= 1'b0;
      resp_ovf    <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (accept) begin
        grant_q <= grant;
        ill_q   <= ~sel_legal;
        if (sel_legal) begin
          alu_opcode <= sel_opcode;
          alu_shamt  <= sel_shamt;
          alu_a      <= sel_a;
          alu_b      <= sel_b;
        end
      end
      if (done) begin
        resp_valid <= grant_q ? 2'b10 : 2'b01;
        if (ill_q) begin
          resp_result <= '0;
          resp_ne     <= 1'b0;
          resp_lt     <= 1'b0;
          resp_ovf    <= 1'b0;
          resp_err    <= 1'b1;
        end else begin
          resp_result <= alu_result;
          resp_ne     <= alu_ne;
          resp_lt     <= alu_lt;
          resp_ovf    <= is_addsub(alu_opcode) & alu_ovf;
          resp_err    <= 1'b0;
        end
      end
      if ((state == ST_RESP) && resp_hs) begin
        resp_valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU attached to each instance.
module tb_alu_share_ctrl;
  import alu_defs_pkg::*;

  typedef struct packed {
    logic [31:0] r;
    logic        ne;
    logic        lt;
    logic        ovf;
  } alu_out_t;

  function automatic alu_out_t alu_model(input logic [4:0] op, input logic [4:0] sh,
                                         input logic [31:0] a, input logic [31:0] b);
    alu_out_t o;
    o.r   = 32'h0;
    o.ovf = 1'b0;
    case (op)
      5'd0: begin o.r = a + b; o.ovf = (a[31] == b[31]) && (o.r[31] != a[31]); end
      5'd1: begin o.r = a - b; o.ovf = (a[31] != b[31]) && (o.r[31] != a[31]); end
      5'd2: o.r = a & b;
      5'd3: o.r = a | b;
      5'd4: o.r = a << sh;
      5'd5: o.r = 32'($signed(a) >>> sh);
      default: o.r = 32'hBAD0BAD0;
    endcase
    o.ne = (a != b);
    o.lt = ($signed(a) < $signed(b));
    return o;
  endfunction

  logic        clock = 1'b0;
  logic        reset, d4_reset;
  logic        force_ovf;
  int          total = 0;
  int          bad = 0;

  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [9:0]  req_opcode, req_shamt;
  logic [63:0] req_a, req_b;
  logic [31:0] resp_result, alu_a, alu_b, alu_result;
  logic        resp_ne, resp_lt, resp_ovf, resp_err, alu_ne, alu_lt, alu_ovf;
  logic [4:0]  alu_opcode, alu_shamt;
  alu_out_t    m0;

  logic [1:0]  d4_req_valid, d4_req_ready, d4_resp_valid, d4_resp_ready;
  logic [9:0]  d4_req_opcode, d4_req_shamt;
  logic [63:0] d4_req_a, d4_req_b;
  logic [31:0] d4_resp_result, d4_alu_a, d4_alu_b;
  logic        d4_resp_ne, d4_resp_lt, d4_resp_ovf, d4_resp_err;
  logic [4:0]  d4_alu_opcode, d4_alu_shamt;
  alu_out_t    m4;

  always #5 clock = ~clock;

  assign m0         = alu_model(alu_opcode, alu_shamt, alu_a, alu_b);
  assign alu_result = m0.r;
  assign alu_ne     = m0.ne;
  assign alu_lt     = m0.lt;
  assign alu_ovf    = m0.ovf | force_ovf;
  assign m4         = alu_model(d4_alu_opcode, d4_alu_shamt, d4_alu_a, d4_alu_b);

  alu_share_ctrl #(.ALU_LATENCY(1)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_shamt(req_shamt), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_ne(resp_ne), .resp_lt(resp_lt), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt), .alu_ovf(alu_ovf)
  );

  alu_share_ctrl #(.ALU_LATENCY(4)) u_dut4 (
    .clock(clock), .reset(d4_reset),
    .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req_opcode(d4_req_opcode), .req_shamt(d4_req_shamt), .req_a(d4_req_a), .req_b(d4_req_b),
    .resp_valid(d4_resp_valid), .resp_ready(d4_resp_ready), .resp_result(d4_resp_result),
    .resp_ne(d4_resp_ne), .resp_lt(d4_resp_lt), .resp_ovf(d4_resp_ovf), .resp_err(d4_resp_err),
    .alu_opcode(d4_alu_opcode), .alu_shamt(d4_alu_shamt), .alu_a(d4_alu_a), .alu_b(d4_alu_b),
    .alu_result(m4.r), .alu_ne(m4.ne), .alu_lt(m4.lt), .alu_ovf(m4.ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;  d4_reset = 1'b1;  force_ovf = 1'b0;
    resp_ready = 2'b00;  d4_resp_ready = 2'b00;
    req_valid = 2'b01;   req_shamt = '0;  d4_req_shamt = '0;
    req_opcode = {ALU_ADD, ALU_ADD};  req_a = {32'h0, 32'h1};  req_b = {32'h0, 32'h10};
    d4_req_valid = 2'b00;  d4_req_opcode = '0;  d4_req_a = '0;  d4_req_b = '0;
    tick(); tick();
    chk("rst_req_ready",  32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_alu_a",      alu_a, 32'h0);
    chk("rst_result",     resp_result, 32'h0);

    // single ADD on port 0
    reset = 1'b0;  #1;
    chk("add_req_ready", 32'(req_ready), 32'h1);
    tick();  req_valid = 2'b00;
    chk("add_no_resp_yet", 32'(resp_valid), 32'h0);
    chk("add_alu_b", alu_b, 32'h10);
    tick();
    chk("add_resp_valid", 32'(resp_valid), 32'h1);
    chk("add_result", resp_result, 32'h11);
    chk("add_ovf", 32'(resp_ovf), 32'h0);
    chk("add_err", 32'(resp_err), 32'h0);
    resp_ready = 2'b01;  tick();  resp_ready = 2'b00;
    chk("add_resp_drop", 32'(resp_valid), 32'h0);

    // illegal opcode on port 1
    req_opcode = {5'b00111, ALU_ADD};  req_a = {32'hDEADBEEF, 32'h0};  req_valid = 2'b10;
    tick();  req_valid = 2'b00;
    chk("ill_no_resp_yet", 32'(resp_valid), 32'h0);
    tick();
    chk("ill_resp_valid", 32'(resp_valid), 32'h2);
    chk("ill_result", resp_result, 32'h0);
    chk("ill_err", 32'(resp_err), 32'h1);
    chk("ill_alu_op_kept", 32'(alu_opcode), 32'h0);
    chk("ill_alu_a_kept", alu_a, 32'h1);
    resp_ready = 2'b10;  tick();  resp_ready = 2'b00;

    // simultaneous SUB (port 0) and OR (port 1)
    req_opcode = {ALU_OR, ALU_SUB};
    req_a = {32'hFFFFFFFF, 32'h10};  req_b = {32'h0, 32'h1};  req_valid = 2'b11;  #1;
    chk("tie_grant_p0", 32'(req_ready), 32'h1);
    tick();  req_valid = 2'b10;
    chk("tie_exec_not_ready", 32'(req_ready), 32'h0);
    tick();
    chk("sub_resp_valid", 32'(resp_valid), 32'h1);
    chk("sub_result", resp_result, 32'h0000000F);
    resp_ready = 2'b01;  tick();  resp_ready = 2'b00;
    chk("or_req_ready", 32'(req_ready), 32'h2);
    tick();  req_valid = 2'b00;
    tick();
    chk("or_resp_valid", 32'(resp_valid), 32'h2);
    chk("or_result", resp_result, 32'hFFFFFFFF);
    chk("or_lt", 32'(resp_lt), 32'h1);
    resp_ready = 2'b10;  tick();  resp_ready = 2'b00;

    // next tie returns to port 0; then back-pressure with port 1 waiting
    req_opcode = {ALU_AND, ALU_ADD};
    req_a = {32'h80000000, 32'h40000000};  req_b = {32'h80000000, 32'h40000000};
    req_valid = 2'b11;  #1;
    chk("tie2_grant_p0", 32'(req_ready), 32'h1);
    tick();  req_valid = 2'b10;
    tick();
    chk("ovf_add_valid", 32'(resp_valid), 32'h1);
    chk("ovf_add_result", resp_result, 32'h80000000);
    chk("ovf_add_flag", 32'(resp_ovf), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_result", resp_result, 32'h80000000);
      chk("bp_p1_not_ready", 32'(req_ready), 32'h0);
    end
    resp_ready = 2'b01;  tick();  resp_ready = 2'b00;  force_ovf = 1'b1;
    chk("bp_p1_ready_after_hs", 32'(req_ready), 32'h2);
    tick();  req_valid = 2'b00;
    chk("and_alu_op", 32'(alu_opcode), 32'(ALU_AND));
    tick();
    chk("and_resp_valid", 32'(resp_valid), 32'h2);
    chk("and_result", resp_result, 32'h80000000);
    chk("and_ovf_masked", 32'(resp_ovf), 32'h0);
    resp_ready = 2'b10;  tick();  resp_ready = 2'b00;  force_ovf = 1'b0;

    // SUB signed overflow
    req_opcode = {ALU_AND, ALU_SUB};  req_a = {32'h0, 32'h80000000};  req_b = {32'h0, 32'h0F000000};
    req_valid = 2'b01;  tick();  req_valid = 2'b00;  tick();
    chk("ovf_sub_result", resp_result, 32'h71000000);
    chk("ovf_sub_flag", 32'(resp_ovf), 32'h1);
    resp_ready = 2'b01;  tick();  resp_ready = 2'b00;

    // reset in the middle of EXEC with a 4-cycle ALU
    d4_reset = 1'b0;
    d4_req_opcode = {ALU_ADD, ALU_ADD};  d4_req_a = {32'h0, 32'h5};  d4_req_b = {32'h0, 32'h3};
    d4_req_valid = 2'b01;  tick();  d4_req_valid = 2'b00;  tick();
    chk("l4_alu_a", d4_alu_a, 32'h5);
    chk("l4_in_exec", 32'(d4_resp_valid), 32'h0);
    #2;  d4_reset = 1'b1;
    d4_req_opcode = {ALU_SUB, ALU_ADD};  d4_req_a = {32'h1, 32'h0};  d4_req_b = {32'h2, 32'h0};
    d4_req_valid = 2'b11;  #1;
    chk("l4_rst_alu_a", d4_alu_a, 32'h0);
    chk("l4_rst_alu_b", d4_alu_b, 32'h0);
    chk("l4_rst_req_ready", 32'(d4_req_ready), 32'h0);
    chk("l4_rst_resp_valid", 32'(d4_resp_valid), 32'h0);
    tick();  d4_reset = 1'b0;  #1;
    chk("l4_tie_p0", 32'(d4_req_ready), 32'h1);
    tick();  d4_req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l4_wait", 32'(d4_resp_valid), 32'h0);
    end
    tick();
    chk("l4_resp_valid", 32'(d4_resp_valid), 32'h1);
    chk("l4_result", d4_resp_result, 32'h0);
    chk("l4_ne", 32'(d4_resp_ne), 32'h0);
    chk("l4_lt", 32'(d4_resp_lt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
